// File: rtl/req_arb_pkg.sv
// Shared types and defaults for the request synchronizer / round-robin arbiter.
package req_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF           = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    // grant_id width; a two-channel arbiter still needs one bit
    function automatic int idw_of(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/req_sync_arbiter_if.sv
// Request/grant bundle between the raw request source, the arbiter and the grant consumer.
interface req_sync_arbiter_if
    import req_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDW   = idw_of(N_REQ)
);
    logic [N_REQ-1:0] req_async;
    logic             grant_ready;
    logic             grant_valid;
    logic [IDW-1:0]   grant_id;
    logic [N_REQ-1:0] pending;
    logic             drop;

    modport master (
        output req_async,
        output grant_ready,
        input  grant_valid,
        input  grant_id,
        input  pending,
        input  drop
    );

    modport slave (
        input  req_async,
        input  grant_ready,
        output grant_valid,
        output grant_id,
        output pending,
        output drop
    );
endinterface

// File: rtl/req_sync_arbiter_input_conditioner.sv
// One request channel: 2-flop synchronizer, counter-based debounce, registered rise pulse.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    logic          r_rise;

    // counter tops out at DEBOUNCE_CYCLES-1 and then resets, so it cannot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
            r_rise <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            if (r_s2 != r_db) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db   <= r_s2;
                    r_cnt  <= '0;
                    r_rise <= r_s2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_rise = r_rise;
endmodule

// File: rtl/req_sync_arbiter.sv
// Debounced asynchronous requests latched into pending flags and served round-robin.
//   state | meaning
//   IDLE  | no grant offered; picks the next pending channel from ptr upward
//   GRANT | grant_valid/grant_id held until grant_ready
module req_sync_arbiter
    import req_arb_pkg::*;
#(
    parameter int N_REQ           = N_REQ_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input logic               clk,
    input logic               rst_n,
    req_sync_arbiter_if.slave arb
);
    localparam int IDW = idw_of(N_REQ);

    logic [N_REQ-1:0] w_rise;
    logic [N_REQ-1:0] w_clr;
    logic             w_accept;
    logic             w_any;
    logic [IDW-1:0]   w_sel;

    arb_state_e       r_state;
    logic [N_REQ-1:0] r_pending;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_gid;
    logic             r_gv;
    logic             r_drop;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N_REQ) s = s - N_REQ;
        return IDW'(s);
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_ch
        input_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_async(arb.req_async[g]),
            .o_rise (w_rise[g])
        );
    end

    // walk downward so the last hit is the nearest channel at or after ptr
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (r_pending[wrap_add(r_ptr, k)]) begin
                w_any = 1'b1;
                w_sel = wrap_add(r_ptr, k);
            end
        end
    end

    assign w_accept = r_gv & arb.grant_ready;
    assign w_clr    = w_accept ? (N_REQ'(1) << r_gid) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_ptr     <= '0;
            r_gid     <= '0;
            r_gv      <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            // a new press outranks the clear of the same bit
            r_pending <= w_rise | (r_pending & ~w_clr);
            r_drop    <= |(w_rise & r_pending & ~w_clr);
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gid   <= w_sel;
                        r_gv    <= 1'b1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_accept) begin
                        r_gv    <= 1'b0;
                        r_ptr   <= wrap_add(r_gid, 1);
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign arb.grant_valid = r_gv;
    assign arb.grant_id    = r_gid;
    assign arb.pending     = r_pending;
    assign arb.drop        = r_drop;
endmodule
